base_fetch_server: RTL

//  Responder for the systolic array's base/prior fetch port. Holds the reference (x) string,
//  the experimental (y) string and per-y-base priors, loaded by the host. Answers x/y index

---
 rtl/base_fetch_server.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/base_fetch_server.sv
// Base/prior fetch responder for the systolic array: holds host-loaded x/y strings and priors,
// answers index requests one cycle later, sequences one alignment and returns its likelihood.
module base_fetch_server #(
    parameter int MAX_LEN = 64,
    parameter int IDX_W   = $clog2(MAX_LEN),
    parameter int BASE_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [IDX_W-1:0]  ld_index,
    input  logic [BASE_W-1:0] ld_base,
    input  logic [63:0]       ld_match,
    input  logic [63:0]       ld_neq,
    input  logic              start,
    input  logic [IDX_W-1:0]  x_len,
    input  logic [IDX_W-1:0]  y_len,
    output logic [IDX_W-1:0]  string_length,
    output logic [IDX_W-1:0]  y_length,
    output logic              array_reset,
    input  logic [IDX_W-1:0]  read_index_x,
    input  logic              read_x_valid,
    input  logic [IDX_W-1:0]  read_index_y,
    input  logic              read_y_valid,
    output logic [BASE_W-1:0] ref_base,
    output logic [BASE_W-1:0] exp_base,
    output logic              base_valid,
    output logic [63:0]       prior_match,
    output logic [63:0]       prior_neq,
    output logic              prior_valid,
    input  logic              complete,
    input  logic [63:0]       final_val,
    output logic [63:0]       result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              err,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_RUN    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_ld_ready;
    logic                r_array_reset;
    logic [IDX_W-1:0]    r_string_length;
    logic [IDX_W-1:0]    r_y_length;
    logic [BASE_W-1:0]   r_ref_base;
    logic [BASE_W-1:0]   r_exp_base;
    logic                r_base_valid;
    logic [63:0]         r_prior_match;
    logic [63:0]         r_prior_neq;
    logic                r_prior_valid;
    logic [63:0]         r_result;
    logic                r_result_valid;
    logic                r_err;

    logic [BASE_W-1:0]   r_x_mem     [MAX_LEN];
    logic [BASE_W-1:0]   r_y_mem     [MAX_LEN];
    logic [63:0]         r_match_mem [MAX_LEN];
    logic [63:0]         r_neq_mem   [MAX_LEN];

    // Load handshake: a beat transfers on any edge where ld_valid and ld_ready are both high;
    // ld_ready is high exactly while in LOAD. result_valid/result_ready follow the same rule.
    logic w_ld_fire;
    logic w_ld_in_range;
    logic w_len_ok;
    logic w_x_oor;
    logic w_y_oor;

    assign w_ld_fire     = ld_valid && r_ld_ready;
    assign w_ld_in_range = int'(ld_index) < MAX_LEN;
    assign w_len_ok      = (x_len != '0) && (int'(x_len) <= MAX_LEN) &&
                           (y_len != '0) && (int'(y_len) <= MAX_LEN);
    assign w_x_oor       = read_index_x >= r_string_length;
    assign w_y_oor       = read_index_y >= r_y_length;

    // String/prior storage carries no reset; contents survive across alignments.
    always_ff @(posedge clk) begin
        if (w_ld_fire && w_ld_in_range) begin
            if (!ld_sel) begin
                r_x_mem[ld_index] <= ld_base;
            end else begin
                r_y_mem[ld_index]     <= ld_base;
                r_match_mem[ld_index] <= ld_match;
                r_neq_mem[ld_index]   <= ld_neq;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_LOAD;
            r_ld_ready      <= 1'b1;
            r_array_reset   <= 1'b1;
            r_string_length <= '0;
            r_y_length      <= '0;
            r_ref_base      <= '0;
            r_exp_base      <= '0;
            r_base_valid    <= 1'b0;
            r_prior_match   <= '0;
            r_prior_neq     <= '0;
            r_prior_valid   <= 1'b0;
            r_result        <= '0;
            r_result_valid  <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_string_length <= x_len;
                            r_y_length      <= y_len;
                            r_err           <= 1'b0;
                            r_base_valid    <= 1'b0;
                            r_prior_valid   <= 1'b0;
                            r_array_reset   <= 1'b0;
                            r_ld_ready      <= 1'b0;
                            r_state         <= S_RUN;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    // A dropped write still flags even if a start clears err on this edge.
                    if (w_ld_fire && !w_ld_in_range) begin
                        r_err <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (read_x_valid) begin
                        r_ref_base   <= w_x_oor ? '0 : r_x_mem[read_index_x];
                        r_base_valid <= 1'b1;
                    end
                    if (read_y_valid) begin
                        r_exp_base    <= w_y_oor ? '0 : r_y_mem[read_index_y];
                        r_prior_match <= w_y_oor ? '0 : r_match_mem[read_index_y];
                        r_prior_neq   <= w_y_oor ? '0 : r_neq_mem[read_index_y];
                        r_prior_valid <= 1'b1;
                    end
                    if ((read_x_valid && w_x_oor) || (read_y_valid && w_y_oor)) begin
                        r_err <= 1'b1;
                    end
                    if (complete) begin
                        r_result       <= final_val;
                        r_result_valid <= 1'b1;
                        r_array_reset  <= 1'b1;
                        r_state        <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (r_result_valid && result_ready) begin
                        r_result_valid <= 1'b0;
                        r_base_valid   <= 1'b0;
                        r_prior_valid  <= 1'b0;
                        r_ld_ready     <= 1'b1;
                        r_state        <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign ld_ready      = r_ld_ready;
    assign array_reset   = r_array_reset;
    assign string_length = r_string_length;
    assign y_length      = r_y_length;
    assign ref_base      = r_ref_base;
    assign exp_base      = r_exp_base;
    assign base_valid    = r_base_valid;
    assign prior_match   = r_prior_match;
    assign prior_neq     = r_prior_neq;
    assign prior_valid   = r_prior_valid;
    assign result        = r_result;
    assign result_valid  = r_result_valid;
    assign err           = r_err;
    assign o_dbg_state   = r_state;

endmodule
